mem_arbiter: RTL and testbench

- Two-port round-robin arbiter sharing the single-port byte memory between two masters, e.g. the UART command controller and a second engine such as a DMA or scanout unit.
- Accepts at most one access per cycle and drives the memory read/write strobes.
- Routes each read byte back to the port that issued it.
- Supports locked bursts with a fairness cap so that neither master can starve the other.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port byte memory.
//
// Only one access can reach the memory per cycle. The grant decision is
// combinational. The memory strobes, address, data and the read-return tag are
// registered. A port may lock ownership for a burst. MAX_BURST limits how many
// locked grants in a row the owner receives while the other port is waiting.
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   pN_req/lock/we/addr/wdata  request fields from master N; they are held
//                           stable until pN_ack is high
//   pN_ack                  combinational accept, high in the grant cycle
//   pN_rdata, pN_rvalid     read return; rvalid is a one-cycle pulse
//   mem_read, mem_write     registered one-cycle strobes to memory
//   mem_addr, mem_wdata     registered address and write data
//   mem_rdata               memory read data, valid the cycle after mem_read
//   owner                   the port currently granted, or the last one granted
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_lock,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [7:0]        p0_wdata,
  output logic              p0_ack,
  output logic [7:0]        p0_rdata,
  output logic              p0_rvalid,
  input  logic              p1_req,
  input  logic              p1_lock,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [7:0]        p1_wdata,
  output logic              p1_ack,
  output logic [7:0]        p1_rdata,
  output logic              p1_rvalid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              owner
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } burst_state_t;

  localparam logic [7:0] CAP = 8'(MAX_BURST);

  burst_state_t      state_reg, state_next;
  logic [7:0]        burst_cnt_reg, burst_cnt_next;
  logic              owner_reg, owner_next;
  logic              mem_read_reg, mem_read_next;
  logic              mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [7:0]        mem_wdata_reg, mem_wdata_next;
  // Records which port issued the access now on the memory strobes. Together
  // with mem_read, it steers the returning byte to the correct port.
  logic              issue_tag_reg, issue_tag_next;
  logic              p0_rvalid_reg, p1_rvalid_reg;

  logic              grant_valid;
  logic              grant_port;
  logic              owner_req, other_req, cap_hit;
  logic              sel_lock, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

  // Registers. The read-return pipeline also clears on reset, so a read that
  // was in flight at reset never produces an rvalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= UNLOCKED;
      burst_cnt_reg <= 8'd0;
      owner_reg     <= 1'b1;   // port 0 wins the first contention
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= 8'd0;
      issue_tag_reg <= 1'b0;
      p0_rvalid_reg <= 1'b0;
      p1_rvalid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
      owner_reg     <= owner_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      issue_tag_reg <= issue_tag_next;
      p0_rvalid_reg <= mem_read_reg & ~issue_tag_reg;
      p1_rvalid_reg <= mem_read_reg &  issue_tag_reg;
    end
  end

  // Arbitration and burst next-state logic.
  always_comb begin
    owner_req = owner_reg ? p1_req : p0_req;
    other_req = owner_reg ? p0_req : p1_req;
    // The owner loses its lock only when it has used its full allowance and
    // the other port is actually waiting.
    cap_hit   = (burst_cnt_reg == CAP) && other_req;

    grant_valid = 1'b0;
    grant_port  = owner_reg;
    if (state_reg == LOCKED && owner_req && !cap_hit) begin
      grant_valid = 1'b1;
      grant_port  = owner_reg;
    end else if (p0_req ^ p1_req) begin
      grant_valid = 1'b1;
      grant_port  = p1_req;
    end else if (p0_req && p1_req) begin
      grant_valid = 1'b1;
      grant_port  = ~owner_reg;
    end

    sel_lock  = grant_port ? p1_lock  : p0_lock;
    sel_we    = grant_port ? p1_we    : p0_we;
    sel_addr  = grant_port ? p1_addr  : p0_addr;
    sel_wdata = grant_port ? p1_wdata : p0_wdata;

    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    owner_next     = owner_reg;
    mem_read_next  = 1'b0;
    mem_write_next = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    issue_tag_next = issue_tag_reg;

    if (grant_valid) begin
      mem_addr_next  = sel_addr;
      mem_wdata_next = sel_wdata;
      mem_write_next = sel_we;
      mem_read_next  = ~sel_we;
      owner_next     = grant_port;
      issue_tag_next = grant_port;
      if (sel_lock) begin
        state_next = LOCKED;
        if (grant_port != owner_reg)
          burst_cnt_next = 8'd1;
        else if (burst_cnt_reg >= CAP)
          burst_cnt_next = CAP;
        else
          burst_cnt_next = burst_cnt_reg + 8'd1;
      end else begin
        state_next     = UNLOCKED;
        burst_cnt_next = 8'd0;
      end
    end
  end

  assign p0_ack    = rst_n & grant_valid & ~grant_port;
  assign p1_ack    = rst_n & grant_valid &  grant_port;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;
  assign p0_rvalid = p0_rvalid_reg;
  assign p1_rvalid = p1_rvalid_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign owner     = owner_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter, built with MAX_BURST = 4.
// Inputs are driven on the falling edge. The combinational acks are checked
// 1 time unit later. Registered outputs are checked on the following falling edge.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              p0_req, p0_lock, p0_we, p1_req, p1_lock, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [7:0]        p0_wdata, p1_wdata;
  logic              p0_ack, p1_ack, p0_rvalid, p1_rvalid;
  logic [7:0]        p0_rdata, p1_rdata;
  logic              mem_read, mem_write, owner;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  int tests = 0;
  int fails = 0;

  // Grant order for the locked burst: p0 x4, p1, p0 x4, p1, p0 x2.
  int burst_seq [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
  );

  // Memory model: fixed contents plus one write slot. Read data arrives one
  // cycle after mem_read.
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  function automatic logic [7:0] rom(input logic [ADDR_W-1:0] a);
    case (a)
      16'h0010: rom = 8'hA5;
      16'h0100: rom = 8'h11;
      16'h0200: rom = 8'h22;
      16'h0300: rom = 8'h33;
      16'h0400: rom = 8'h44;
      default:  rom = a[7:0];
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_write) begin
      wr_valid <= 1'b1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
    if (mem_read)
      mem_rdata <= (wr_valid && wr_addr == mem_addr) ? wr_data : rom(mem_addr);
  end

  // Print one line per accepted transaction.
  always @(negedge clk) begin
    #2;
    if (p0_ack) $display("[TB] t=%0t grant p0 addr=%h we=%0d", $time, p0_addr, p0_we);
    if (p1_ack) $display("[TB] t=%0t grant p1 addr=%h we=%0d", $time, p1_addr, p1_we);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ack(input string tag, input logic a0, input logic a1);
    #1;
    chk({tag, " p0_ack"}, 32'(p0_ack), 32'(a0));
    chk({tag, " p1_ack"}, 32'(p1_ack), 32'(a1));
  endtask

  task automatic idle();
    p0_req = 1'b0;
    p1_req = 1'b0;
    p0_lock = 1'b0;
    p1_lock = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = 8'd0; p1_wdata = 8'd0;

    // ---- Reset state and ack masking during reset
    repeat (3) @(negedge clk);
    chk("rst mem_read", 32'(mem_read), 32'd0);
    chk("rst mem_write", 32'(mem_write), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'h0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst owner", 32'(owner), 32'd1);
    chk("rst rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    p0_req = 1'b1; p1_req = 1'b1;
    chk_ack("rst masked", 1'b0, 1'b0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Contention after reset: p0, p1, p0, p1 alternating reads
    p0_addr = 16'h0100; p1_addr = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      if (i >= 1 && i <= 4) begin
        chk("cont mem_read", 32'(mem_read), 32'd1);
        chk("cont mem_addr", 32'(mem_addr), ((i - 1) % 2 == 0) ? 32'h0100 : 32'h0200);
      end
      if (i >= 2) begin
        chk("cont p0_rvalid", 32'(p0_rvalid), ((i - 2) % 2 == 0) ? 32'd1 : 32'd0);
        chk("cont p1_rvalid", 32'(p1_rvalid), ((i - 2) % 2 == 1) ? 32'd1 : 32'd0);
        chk("cont rdata", 32'(((i - 2) % 2 == 0) ? p0_rdata : p1_rdata),
            ((i - 2) % 2 == 0) ? 32'h11 : 32'h22);
      end
      p0_req = (i < 4); p1_req = (i < 4);
      chk_ack("cont", (i < 4) && (i % 2 == 0), (i < 4) && (i % 2 == 1));
      @(negedge clk);
    end
    idle();

    // ---- Single read on p0
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    chk_ack("rd A", 1'b1, 1'b0);
    @(negedge clk);
    chk("rd A+1 mem_read", 32'(mem_read), 32'd1);
    chk("rd A+1 mem_write", 32'(mem_write), 32'd0);
    chk("rd A+1 mem_addr", 32'(mem_addr), 32'h0010);
    chk("rd A+1 owner", 32'(owner), 32'd0);
    idle();
    chk_ack("rd A+1", 1'b0, 1'b0);
    @(negedge clk);
    chk("rd A+2 p0_rvalid", 32'(p0_rvalid), 32'd1);
    chk("rd A+2 p0_rdata", 32'(p0_rdata), 32'hA5);
    chk("rd A+2 p1_rvalid", 32'(p1_rvalid), 32'd0);
    chk("rd A+2 mem_read", 32'(mem_read), 32'd0);
    @(negedge clk);
    chk("rd A+3 p0_rvalid", 32'(p0_rvalid), 32'd0);

    // ---- Write then read on p1
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 16'h1234; p1_wdata = 8'h3C;
    chk_ack("wr A", 1'b0, 1'b1);
    @(negedge clk);
    chk("wr mem_write", 32'(mem_write), 32'd1);
    chk("wr mem_read", 32'(mem_read), 32'd0);
    chk("wr mem_addr", 32'(mem_addr), 32'h1234);
    chk("wr mem_wdata", 32'(mem_wdata), 32'h3C);
    p1_we = 1'b0;
    chk_ack("wrrd A", 1'b0, 1'b1);
    @(negedge clk);
    chk("wrrd mem_read", 32'(mem_read), 32'd1);
    chk("wrrd mem_write", 32'(mem_write), 32'd0);
    chk("wr no rvalid", {30'd0, p0_rvalid, p1_rvalid}, 32'd0);
    idle();
    @(negedge clk);
    chk("wrrd p1_rvalid", 32'(p1_rvalid), 32'd1);
    chk("wrrd p1_rdata", 32'(p1_rdata), 32'h3C);
    chk("wrrd p0_rvalid", 32'(p0_rvalid), 32'd0);
    repeat (2) @(negedge clk);

    // ---- Locked burst on p0 with p1 waiting, cap of 4
    begin
      int n0 = 0;
      int n1 = 0;
      p0_addr = 16'h0300; p0_we = 1'b0;
      p1_addr = 16'h0400; p1_we = 1'b0;
      for (int i = 0; i < 14; i++) begin
        if (i >= 1 && i <= 12) chk("burst mem_read", 32'(mem_read), 32'd1);
        if (i >= 2) begin
          chk("burst p0_rvalid", 32'(p0_rvalid), (burst_seq[i - 2] == 0) ? 32'd1 : 32'd0);
          chk("burst p1_rvalid", 32'(p1_rvalid), (burst_seq[i - 2] == 1) ? 32'd1 : 32'd0);
        end
        p0_req = (n0 < 10); p0_lock = (n0 < 10);
        p1_req = (n1 < 2);
        if (i < 12) begin
          chk_ack("burst", burst_seq[i] == 0, burst_seq[i] == 1);
          if (burst_seq[i] == 0) n0++; else n1++;
        end else begin
          chk_ack("burst done", 1'b0, 1'b0);
        end
        @(negedge clk);
      end
      idle();
    end

    // ---- Lock with no contention: 20 consecutive p0 grants
    p0_addr = 16'h0300;
    for (int i = 0; i < 20; i++) begin
      p0_req = 1'b1; p0_lock = 1'b1;
      chk_ack("solo lock", 1'b1, 1'b0);
      @(negedge clk);
      chk("solo mem_read", 32'(mem_read), 32'd1);
      chk("solo owner", 32'(owner), 32'd0);
    end
    idle();
    repeat (2) @(negedge clk);

    // ---- Reset while a p0 read is in flight
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    chk_ack("rstrd A", 1'b1, 1'b0);
    @(negedge clk);
    chk("rstrd A+1 mem_read", 32'(mem_read), 32'd1);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstrd p0_rvalid", 32'(p0_rvalid), 32'd0);
    chk("rstrd mem_read", 32'(mem_read), 32'd0);
    chk("rstrd mem_addr", 32'(mem_addr), 32'h0);
    chk("rstrd owner", 32'(owner), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstrd late rvalid", 32'(p0_rvalid), 32'd0);
    p0_addr = 16'h0100; p1_addr = 16'h0200;
    p0_req = 1'b1; p1_req = 1'b1;
    chk_ack("rstrd cont", 1'b1, 1'b0);
    @(negedge clk);
    chk("rstrd cont owner", 32'(owner), 32'd0);
    idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
